ll_fifo_reader: RTL and testbench

LL_FIFO_READER -- requirements
Module: ll_fifo_reader

---
 rtl/ll_fifo_reader.sv | 102 ++++++++++
 tb/tb_ll_fifo_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ll_fifo_reader.sv
// Drains a shared linked-list FIFO into a 2-entry output buffer, picking among
// the eligible logical queues round-robin. Each word is tagged with its queue index.
module ll_fifo_reader #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_FIFOS = 2,
  parameter int unsigned ID_WIDTH  = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_FIFOS-1:0] fifo_mask,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  output logic [NUM_FIFOS-1:0] fifo_pop,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [ID_WIDTH-1:0]  out_id,
  output logic [15:0]          drained_count
);

  logic [NUM_FIFOS-1:0] elig;
  logic [ID_WIDTH-1:0]  last_q;
  logic [ID_WIDTH-1:0]  grant_id;
  logic                 grant_vld;
  logic                 credit_ok;
  logic                 pop_fire;
  logic                 accept;

  logic                 inflight_q;
  logic [ID_WIDTH-1:0]  inflight_id_q;
  logic [WIDTH-1:0]     buf_data_q [2];
  logic [ID_WIDTH-1:0]  buf_id_q   [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           cnt_q;
  logic [15:0]          drained_q;

  assign elig = ~fifo_empty & fifo_mask;

  // Credit counts only registered occupancy, so out_ready never reaches fifo_pop.
  assign credit_ok = ({1'b0, cnt_q} + {2'b00, inflight_q}) < 3'd2;

  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned k = 1; k <= NUM_FIFOS; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
      if (!grant_vld && elig[ID_WIDTH'(idx)]) begin
        grant_vld = 1'b1;
        grant_id  = ID_WIDTH'(idx);
      end
    end
  end

  assign pop_fire = grant_vld && credit_ok && en && !rst;

  always_comb begin
    fifo_pop = '0;
    if (pop_fire) fifo_pop[grant_id] = 1'b1;
  end

  assign out_valid     = (cnt_q != 2'd0);
  assign out_data      = buf_data_q[rd_ptr_q];
  assign out_id        = buf_id_q[rd_ptr_q];
  assign accept        = out_valid && out_ready;
  assign drained_count = drained_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q        <= ID_WIDTH'(NUM_FIFOS - 1);
      inflight_q    <= 1'b0;
      inflight_id_q <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      cnt_q         <= '0;
      drained_q     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_id_q[i]   <= '0;
      end
    end else begin
      if (pop_fire) last_q <= grant_id;
      inflight_q    <= pop_fire;
      inflight_id_q <= grant_id;
      if (inflight_q) begin
        buf_data_q[wr_ptr_q] <= fifo_data;
        buf_id_q[wr_ptr_q]   <= inflight_id_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (accept) begin
        rd_ptr_q  <= ~rd_ptr_q;
        drained_q <= drained_q + 16'd1;
      end
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, accept};
    end
  end

endmodule

// File: tb/tb_ll_fifo_reader.sv
// Bench for ll_fifo_reader: queue-based model of the shared FIFO and the reader,
// compared against the DUT every cycle, plus directed scenarios with literal results.
module tb_ll_fifo_reader;
  localparam int N = 2;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [N-1:0] fifo_mask = '0;
  logic [N-1:0] fifo_empty = '1;
  logic [N-1:0] fifo_pop;
  logic [W-1:0] fifo_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [0:0]   out_id;
  logic [15:0]  drained_count;

  ll_fifo_reader #(.WIDTH(W), .NUM_FIFOS(N)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_mask(fifo_mask), .fifo_empty(fifo_empty),
    .fifo_pop(fifo_pop), .fifo_data(fifo_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .drained_count(drained_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Shared-FIFO contents per queue, and the reader model: buffered words,
  // the outstanding pop, last granted queue, accepted-word count.
  logic [W-1:0] src [N][$];
  logic [N-1:0] force_empty = '0;
  logic [W-1:0] mq_d[$];
  int           mq_id[$];
  bit           m_inf = 0;
  int           m_inf_id = 0;
  int           m_last = N - 1;
  logic [15:0]  m_cnt = '0;
  bit           live = 0;

  int           pops_log[$];
  logic [W-1:0] acc_d[$];
  int           acc_id[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [N-1:0] elig, exp_pop;
    logic [W-1:0] word;
    int g;
    for (int i = 0; i < N; i++) fifo_empty[i] = (src[i].size() == 0) || force_empty[i];
    @(negedge clk);
    elig = ~fifo_empty & fifo_mask;
    exp_pop = '0;
    g = -1;
    if (!rst && en && (mq_d.size() + int'(m_inf)) < 2)
      for (int k = 1; k <= N; k++)
        if (g < 0 && elig[(m_last + k) % N]) g = (m_last + k) % N;
    if (g >= 0) exp_pop[g] = 1'b1;

    chk("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
    chk("pop_onehot0", 32'($onehot0(fifo_pop)), 32'd1);
    chk("pop_illegal", 32'((rst || !en) ? fifo_pop : (fifo_pop & ~elig)), 32'd0);
    if (live) begin
      chk("out_valid", 32'(out_valid), 32'(mq_d.size() > 0));
      if (mq_d.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(mq_d[0]));
        chk("out_id", 32'(out_id), 32'(mq_id[0]));
      end
      chk("drained_count", 32'(drained_count), 32'(m_cnt));
    end

    for (int i = 0; i < N; i++) if (fifo_pop[i]) pops_log.push_back(i);
    if (out_valid && out_ready) begin
      acc_d.push_back(out_data);
      acc_id.push_back(int'(out_id));
    end

    if (rst) begin
      mq_d.delete();
      mq_id.delete();
      m_inf = 0;
      m_last = N - 1;
      m_cnt = '0;
      live = 1;
    end else begin
      if (mq_d.size() > 0 && out_ready) begin
        void'(mq_d.pop_front());
        void'(mq_id.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (m_inf) begin
        mq_d.push_back(fifo_data);
        mq_id.push_back(m_inf_id);
      end
      m_inf = (g >= 0);
      if (g >= 0) begin
        m_inf_id = g;
        m_last = g;
      end
    end
    word = W'($urandom);
    if (g >= 0) word = src[g].pop_front();
    @(posedge clk);
    #1;
    fifo_data = word;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_logs();
    pops_log.delete();
    acc_d.delete();
    acc_id.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    steps(2);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_drained", 32'(drained_count), 32'd0);
    rst = 1'b0;

    // Two queues of 3 words each alternate
    clear_logs();
    src[0] = '{8'h10, 8'h11, 8'h12};
    src[1] = '{8'h20, 8'h21, 8'h22};
    fifo_mask = 2'b11; en = 1'b1; out_ready = 1'b1;
    steps(20);
    chk("rr_pop_count", 32'(pops_log.size()), 32'd6);
    chk("rr_acc_count", 32'(acc_id.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < pops_log.size()) chk("rr_pop_order", 32'(pops_log[i]), 32'(i % 2));
      if (i < acc_id.size()) chk("rr_id_order", 32'(acc_id[i]), 32'(i % 2));
    end
    if (acc_d.size() > 3) chk("rr_data3", 32'(acc_d[3]), 32'h21);
    chk("rr_drained", 32'(drained_count), 32'd6);

    // Backpressure: only two pops, head word held
    do_reset();
    clear_logs();
    src[0] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    fifo_mask = 2'b01; out_ready = 1'b0;
    steps(8);
    chk("bp_pops", 32'(pops_log.size()), 32'd2);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head", 32'(out_data), 32'hA0);
    out_ready = 1'b1;
    steps(15);
    chk("bp_acc_count", 32'(acc_d.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < acc_d.size()) chk("bp_acc_data", 32'(acc_d[i]), 32'hA0 + 32'(i));

    // Masked queue is never popped until unmasked
    do_reset();
    clear_logs();
    src[1] = '{8'h31, 8'h32};
    fifo_mask = 2'b01;
    steps(5);
    chk("mask_no_pop", 32'(pops_log.size()), 32'd0);
    fifo_mask = 2'b11;
    step();
    chk("unmask_pop_count", 32'(pops_log.size()), 32'd1);
    if (pops_log.size() > 0) chk("unmask_pop_idx", 32'(pops_log[0]), 32'd1);
    steps(6);

    // en drops after a pop: word still delivered, no more pops
    do_reset();
    clear_logs();
    src[0] = '{8'h51, 8'h52, 8'h53};
    fifo_mask = 2'b01; en = 1'b1;
    step();
    en = 1'b0;
    steps(10);
    chk("en_pops", 32'(pops_log.size()), 32'd1);
    chk("en_acc_count", 32'(acc_d.size()), 32'd1);
    if (acc_d.size() > 0) chk("en_acc_data", 32'(acc_d[0]), 32'h51);

    // Reset with two words buffered, then first grant is queue 0
    src[0].push_back(8'h61);
    src[0].push_back(8'h62);
    en = 1'b1; out_ready = 1'b0;
    steps(6);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_drained", 32'(drained_count), 32'd1);
    do_reset();
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_drained", 32'(drained_count), 32'd0);
    clear_logs();
    src[1].push_back(8'h71);
    fifo_mask = 2'b11; out_ready = 1'b1;
    steps(4);
    if (pops_log.size() > 0) chk("post_rst_grant", 32'(pops_log[0]), 32'd0);
    else chk("post_rst_grant_seen", 32'd0, 32'd1);
    steps(12);

    // Randomized traffic
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      en = ($urandom_range(0, 9) != 0);
      fifo_mask = N'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) begin
        force_empty[i] = ($urandom_range(0, 3) == 0);
        if (src[i].size() < 6 && $urandom_range(0, 1) == 1) src[i].push_back(W'($urandom));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
